// File: rtl/conv3x3_engine.sv
`default_nettype none
//============================================================================
// Module   : conv3x3_engine
// Purpose  : Sequential 3x3 convolution. It accepts one pixel window and one
//            packed kernel per transaction. It returns the weighted sum divided
//            by the coefficient sum, as an 8-bit pixel with floor rounding
//            and saturation.
//            The datapath uses one shared multiplier and an iterative
//            restoring divider.
// Ports    : clk        rising-edge clock
//            reset_n    asynchronous active-low reset
//            kernel     9 packed coefficients, c0 in the top bits (row-major)
//            window     9 packed pixels, p0 in the top bits (row-major)
//            in_valid   / in_ready   input handshake (ready only in IDLE)
//            out_pixel  / out_valid  / out_ready  output handshake
//            busy       high whenever the engine is not IDLE
// Macro    : CONV_POW2_FAST_EN - a power-of-two coefficient sum is normalised
//            with a shift (10-cycle latency) instead of the divider
//            (26-cycle latency). The result value is the same in both builds.
// Revision : 1.0 - initial release
//============================================================================
module conv3x3_engine #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9*COEF_W-1:0]   kernel,
    input  logic [9*PIX_W-1:0]    window,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PIX_W-1:0]      out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    // Nine products of (2^C-1)*(2^P-1) always fit in P+C+4 bits.
    localparam int ACC_W  = PIX_W + COEF_W + 4;
    localparam int KSUM_W = COEF_W + 4;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_MAC  = 3'd1;
    localparam logic [2:0] c_S_DIV  = 3'd2;
    localparam logic [2:0] c_S_NORM = 3'd3;
    localparam logic [2:0] c_S_OUT  = 3'd4;

    localparam logic [3:0] c_IDX_LAST = 4'd8;
    localparam logic [4:0] c_DIV_LAST = 5'(ACC_W - 1);

    logic [2:0]                r_state;
    logic [8:0][COEF_W-1:0]    r_kernel;
    logic [8:0][PIX_W-1:0]     r_window;
    logic [ACC_W-1:0]          r_acc;
    logic [KSUM_W-1:0]         r_ksum;
    logic [3:0]                r_idx;
    logic [4:0]                r_divcnt;
    logic [KSUM_W-1:0]         r_rem;
    logic [ACC_W-1:0]          r_quot;
    logic [PIX_W-1:0]          r_pixel;
    logic                      r_out_valid;

    function automatic logic [PIX_W-1:0] f_sat(input logic [ACC_W-1:0] v);
        if (|v[ACC_W-1:PIX_W]) begin
            return '1;
        end
        return v[PIX_W-1:0];
    endfunction

    // MAC datapath. Element 8 of the packed arrays holds c0/p0.
    logic [3:0]                w_sel;
    logic [COEF_W-1:0]         w_coef;
    logic [PIX_W-1:0]          w_pix;
    logic [COEF_W+PIX_W-1:0]   w_prod;
    logic [ACC_W-1:0]          w_acc_sum;
    logic [KSUM_W-1:0]         w_ksum_sum;

    assign w_sel      = c_IDX_LAST - r_idx;
    assign w_coef     = r_kernel[w_sel];
    assign w_pix      = r_window[w_sel];
    assign w_prod     = w_coef * w_pix;
    assign w_acc_sum  = r_acc + ACC_W'(w_prod);
    assign w_ksum_sum = r_ksum + KSUM_W'(w_coef);

    // Restoring divider step. The remainder stays below ksum, so after the
    // shift it needs only one extra bit.
    logic [KSUM_W:0]           w_div_shift;
    logic                      w_div_ge;
    logic [KSUM_W:0]           w_div_rem;
    logic [ACC_W-1:0]          w_div_quot;

    assign w_div_shift = {r_rem, r_quot[ACC_W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_ksum});
    assign w_div_rem   = w_div_ge ? (w_div_shift - {1'b0, r_ksum}) : w_div_shift;
    assign w_div_quot  = {r_quot[ACC_W-2:0], w_div_ge};

    // Shift normalisation for a power-of-two ksum.
    logic                      w_mac_pow2;
    logic [ACC_W-1:0]          w_norm_val;

`ifdef CONV_POW2_FAST_EN
    logic [3:0]                w_shamt;

    assign w_mac_pow2 = ((w_ksum_sum & (w_ksum_sum - 1'b1)) == '0);

    always_comb begin
        w_shamt = '0;
        for (int i = 0; i < KSUM_W; i++) begin
            if (r_ksum[i]) begin
                w_shamt = 4'(i);
            end
        end
    end

    assign w_norm_val = r_acc >> w_shamt;
`else
    assign w_mac_pow2 = 1'b0;
    assign w_norm_val = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_S_IDLE;
            r_kernel    <= '0;
            r_window    <= '0;
            r_acc       <= '0;
            r_ksum      <= '0;
            r_idx       <= '0;
            r_divcnt    <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_pixel     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_kernel <= kernel;
                        r_window <= window;
                        r_acc    <= '0;
                        r_ksum   <= '0;
                        r_idx    <= '0;
                        r_state  <= c_S_MAC;
                    end
                end
                c_S_MAC: begin
                    r_acc  <= w_acc_sum;
                    r_ksum <= w_ksum_sum;
                    r_idx  <= r_idx + 4'd1;
                    if (r_idx == c_IDX_LAST) begin
                        if ((w_ksum_sum == '0) || w_mac_pow2) begin
                            r_state <= c_S_NORM;
                        end else begin
                            r_quot   <= w_acc_sum;
                            r_rem    <= '0;
                            r_divcnt <= '0;
                            r_state  <= c_S_DIV;
                        end
                    end
                end
                c_S_DIV: begin
                    r_quot   <= w_div_quot;
                    r_rem    <= w_div_rem[KSUM_W-1:0];
                    r_divcnt <= r_divcnt + 5'd1;
                    if (r_divcnt == c_DIV_LAST) begin
                        r_pixel     <= f_sat(w_div_quot);
                        r_out_valid <= 1'b1;
                        r_state     <= c_S_OUT;
                    end
                end
                c_S_NORM: begin
                    // A zero-sum kernel yields black.
                    r_pixel     <= (r_ksum == '0) ? '0 : f_sat(w_norm_val);
                    r_out_valid <= 1'b1;
                    r_state     <= c_S_OUT;
                end
                c_S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_S_IDLE);
    assign busy      = (r_state != c_S_IDLE);
    assign out_valid = r_out_valid;
    assign out_pixel = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
`default_nettype none
//============================================================================
// Module   : tb_conv3x3_engine
// Purpose  : Directed self-checking bench for conv3x3_engine. It checks
//            result values, latency, back-pressure and mid-transaction reset.
//            The expected pixels are hand-computed.
//            Latency expectations follow CONV_POW2_FAST_EN.
// Revision : 1.0 - initial release
//============================================================================
module tb_conv3x3_engine;

    localparam int LAT_DIV  = 26;
    localparam int LAT_NORM = 10;
`ifdef CONV_POW2_FAST_EN
    localparam int LAT_POW2 = LAT_NORM;
`else
    localparam int LAT_POW2 = LAT_DIV;
`endif

    logic        clk;
    logic        reset_n;
    logic [44:0] kernel;
    logic [71:0] window;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_pixel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_assert;
    int n_fail;

    conv3x3_engine #(
        .PIX_W  (8),
        .COEF_W (5)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .kernel    (kernel),
        .window    (window),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Run one transaction. Check the latency and the pixel, then hold
    // out_ready low for 'hold' cycles with a competing in_valid pulse before
    // completing the output handshake.
    task automatic run_txn(input string tag, input logic [44:0] k, input logic [71:0] w,
                           input logic [7:0] exp_pix, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check_eq({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        kernel   = k;
        window   = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // The engine must use only the values captured on the accept edge.
        kernel   = 45'({$urandom, $urandom});
        window   = 72'({$urandom, $urandom, $urandom});
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " pixel"}, 32'(out_pixel), 32'(exp_pix));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            window   = 72'({$urandom, $urandom, $urandom});
            @(posedge clk);
            #1;
            check_eq({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, " hold pixel"}, 32'(out_pixel), 32'(exp_pix));
            check_eq({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        check_eq({tag, " busy idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        kernel    = '0;
        window    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset out_pixel", 32'(out_pixel), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset in_ready", 32'(in_ready), 32'd1);

        // Identity kernel: ksum=1, a power of two.
        run_txn("identity", {20'd0, 5'd1, 20'd0},
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                8'h5A, LAT_POW2, 0);
        // Box blur: 450/9 = 50.
        run_txn("box", {9{5'd1}},
                {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90},
                8'd50, LAT_DIV, 0);
        // Box blur with floor: 10/9 = 1.
        run_txn("box floor", {9{5'd1}}, {{8{8'd1}}, 8'd2}, 8'd1, LAT_DIV, 0);
        // Gaussian: 3200/16 = 200.
        run_txn("gauss", {5'd1, 5'd2, 5'd1, 5'd2, 5'd4, 5'd2, 5'd1, 5'd2, 5'd1},
                {9{8'd200}}, 8'd200, LAT_POW2, 0);
        // Zero kernel: black after 10 edges.
        run_txn("zero", '0, 72'h0123_4567_89AB_CDEF_55, 8'd0, LAT_NORM, 0);
        // Non-power-of-two ksum=7: (3*100 + 4*7)/7 = 328/7 = 46.
        run_txn("ksum7", {5'd3, 5'd4, 35'd0}, {8'd100, 8'd7, 56'hFFFF_FFFF_FFFF_FF},
                8'd46, LAT_DIV, 0);
        // Full-scale case: all coefficients 31 and all pixels 255 give
        // 71145/279 = 255.
        run_txn("fullscale", {9{5'd31}}, {9{8'd255}}, 8'd255, LAT_DIV, 0);
        // Power-of-two ksum=8 with a fractional result: 335/8 = 41.
        run_txn("ksum8", {5'd3, 5'd5, 35'd0}, {8'd100, 8'd7, 56'd0}, 8'd41, LAT_POW2, 0);
        // Back-pressure for 5 cycles with a competing in_valid.
        run_txn("backpressure", {5'd1, 5'd2, 5'd1, 5'd2, 5'd4, 5'd2, 5'd1, 5'd2, 5'd1},
                {9{8'd200}}, 8'd200, LAT_POW2, 5);

        // Reset at edge 15 of a box blur. out_pixel still holds 200 here.
        @(negedge clk);
        kernel   = {9{5'd1}};
        window   = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("pre-reset busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midreset out_valid", 32'(out_valid), 32'd0);
        check_eq("midreset out_pixel", 32'(out_pixel), 32'd0);
        check_eq("midreset busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("release in_ready", 32'(in_ready), 32'd1);
        check_eq("release busy", 32'(busy), 32'd0);
        check_eq("release out_valid", 32'(out_valid), 32'd0);
        run_txn("box after reset", {9{5'd1}},
                {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90},
                8'd50, LAT_DIV, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
